regfile_ctrl: RTL
=================

# regfile_ctrl

Sequencing controller in front of the renaming register file. Accepts rename requests from the decoder and commit writebacks from the ROB, and drives the register file's single update port plus its occupy port. On a branch-mispredict flush, it runs a busy-clear walk over all architectural registers. Sits between decoder/ROB and the register file; the register file itself is unchanged apart from a CLEAR op on its update port.

## Interface
- REG_W, 5: architectural register index width; register 0 is hard zero.
- ROB_W, 4: ROB tag width.
- DATA_W, 32: data width.
- CQ_DEPTH, 4: commit queue depth, power of two.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dec_valid / dec_ready  in / out  1  rename handshake; a transfer happens when both are 1 at a clk edge.
- dec_rd  in  REG_W  destination register.
- dec_tag  in  ROB_W  ROB tag allocated for the destination.
- rob_valid / rob_ready  in / out  1  commit handshake.
- rob_rd, rob_tag, rob_value  in  REG_W / ROB_W / DATA_W  committed destination, tag and value.
- flush  in  1  single-cycle mispredict pulse.
- rf_ena  out  1  register file enable; high whenever any rf_* op is valid.
- rf_occ_reg, rf_occ_tag  out  REG_W / ROB_W  occupy request; rf_occ_reg = 0 means none.
- rf_upd_op  out  2  update op: 0 NONE, 1 COMMIT, 2 CLEAR.
- rf_upd_reg, rf_upd_tag, rf_upd_value  out  REG_W / ROB_W / DATA_W  update operands.
- busy_flush  out  1  high in WALK and DRAIN.

## Operation
- All rf_* outputs are registered.
- Reset values: all rf_* outputs are 0, with rf_upd_op = NONE.
  - State resets to RUN, with an empty queue and walk index 1.
  - dec_ready and rob_ready are 1 out of reset.
- States:
  - RUN: renames and commits flow normally.
  - WALK: clears registers 1..2^REG_W-1, one per cycle.
  - DRAIN: empties the commit queue.
- RUN:
  - dec_ready = 1.
  - Each accepted rename produces an occupy op. A rename with dec_rd = 0 is accepted and dropped (rf_occ_reg stays 0).
  - Commits go through the commit queue. When the queue is empty, an incoming commit bypasses it directly into the update register.
  - rob_ready = queue not full.
  - Commits with rob_rd = 0 are accepted and dropped.
- flush in RUN → WALK at the next edge.
  - A rename or commit handshaking in the same cycle as flush is still honoured.
  - dec_ready = 0 from the next cycle.
- WALK:
  - The update port carries op CLEAR, reg = index, tag = 0, value = 0. The register file sets busy = 0 and tag = 0 for that register, and data is kept.
  - The index increments by 1. After issuing register 2^REG_W-1 → DRAIN, and the index reloads to 1.
  - Commits are still accepted into the queue while it is not full; none reach the port.
- DRAIN:
  - The queue pops one entry per cycle as COMMIT.
  - The bypass is disabled.
  - → RUN at the edge when the queue is empty and no commit is being accepted.
  - dec_ready = 0 throughout, so a pre-flush commit tag cannot match a post-flush rename.
- flush while in WALK or DRAIN restarts WALK at index 1. The queue contents are kept.
- Queue full: rob_ready = 0. A simultaneous pop and push while full is not allowed, because ready is computed from the registered count.
- Reset asserted mid-operation: immediate return to the reset state. The queue and walk are discarded.

## Timing
- Rename accepted at edge N → rf_occ_* valid during cycle N..N+1 (one-cycle latency).
- Commit accepted at edge N with an empty queue in RUN → COMMIT on the port during cycle N..N+1.
- Queued commits pop in FIFO order, one per cycle, with no bubbles.
- Flush at edge N:
  - CLEAR of register 1 is on the port during cycle N+1.
  - Register 2^REG_W-1 is cleared in cycle N+2^REG_W-1.
  - DRAIN lasts max(1, queue occupancy) cycles.
- Occupy and update can target the same register in the same cycle; the register file gives occupy priority. The controller neither reorders nor suppresses either op.

## Structure
- Shared package holds:
  - op encodings UPD_NONE / UPD_COMMIT / UPD_CLEAR;
  - state encodings RUN / WALK / DRAIN;
  - the width constants already used by the register file.
- One sub-module: commit_queue, a synchronous FIFO of {rd, tag, value}, CQ_DEPTH entries, with count output and wrap-around pointers.

## Test plan
- Reset, then rename (rd 5, tag 3) → next cycle rf_occ_reg = 5, rf_occ_tag = 3, rf_ena = 1. Rename of rd 0 → rf_occ_reg stays 0.
- Commit (rd 7, tag 2, value 0xDEADBEEF) in RUN with an empty queue → next cycle COMMIT reg 7, tag 2, value 0xDEADBEEF.
- Flush pulse → CLEAR for registers 1..31 on 31 consecutive cycles, dec_ready = 0, busy_flush = 1, then RUN with dec_ready = 1.
- During WALK, push 5 commits with CQ_DEPTH = 4 → rob_ready drops after 4 accepted. DRAIN emits exactly those 4 in order, then RUN.
- Second flush mid-WALK at index 12 → walk restarts at register 1. The total CLEAR count equals 31 after the second flush.
- Assert rst low mid-DRAIN with the queue holding 3 → outputs are 0 immediately, and after release the next commit bypasses the queue (the queue is empty).

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file sequencing controller.
package regfile_ctrl_pkg;

    localparam int REG_W    = 5;
    localparam int ROB_W    = 4;
    localparam int DATA_W   = 32;
    localparam int CQ_DEPTH = 4;
    localparam int CQ_AW    = $clog2(CQ_DEPTH);

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [ROB_W-1:0]  rob_tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CQ_AW:0]    cq_cnt_t;

    typedef enum logic [1:0] {
        UPD_NONE   = 2'd0,
        UPD_COMMIT = 2'd1,
        UPD_CLEAR  = 2'd2
    } upd_op_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WALK  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        reg_idx_t rd;
        rob_tag_t tag;
        data_t    value;
    } cq_entry_t;

    localparam cq_cnt_t  CQ_FULL    = cq_cnt_t'(CQ_DEPTH);
    localparam reg_idx_t WALK_FIRST = reg_idx_t'(1);
    localparam reg_idx_t WALK_LAST  = '1;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Decoder/ROB/flush inputs and register-file port outputs of the controller.
interface regfile_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic     dec_valid;
    logic     dec_ready;
    reg_idx_t dec_rd;
    rob_tag_t dec_tag;

    logic     rob_valid;
    logic     rob_ready;
    reg_idx_t rob_rd;
    rob_tag_t rob_tag;
    data_t    rob_value;

    logic     flush;

    logic     rf_ena;
    reg_idx_t rf_occ_reg;
    rob_tag_t rf_occ_tag;
    upd_op_e  rf_upd_op;
    reg_idx_t rf_upd_reg;
    rob_tag_t rf_upd_tag;
    data_t    rf_upd_value;
    logic     busy_flush;

    // Environment side: decoder, ROB and mispredict source.
    modport master (
        output dec_valid, dec_rd, dec_tag,
        output rob_valid, rob_rd, rob_tag, rob_value,
        output flush,
        input  dec_ready, rob_ready,
        input  rf_ena, rf_occ_reg, rf_occ_tag,
        input  rf_upd_op, rf_upd_reg, rf_upd_tag, rf_upd_value,
        input  busy_flush
    );

    // Controller side.
    modport slave (
        input  dec_valid, dec_rd, dec_tag,
        input  rob_valid, rob_rd, rob_tag, rob_value,
        input  flush,
        output dec_ready, rob_ready,
        output rf_ena, rf_occ_reg, rf_occ_tag,
        output rf_upd_op, rf_upd_reg, rf_upd_tag, rf_upd_value,
        output busy_flush
    );

endinterface

// File: rtl/regfile_ctrl_commit_queue.sv
// Synchronous FIFO holding committed {rd, tag, value} while the update port is busy.
module regfile_ctrl_commit_queue
    import regfile_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  cq_entry_t i_din,
    input  logic      i_pop,
    output cq_entry_t o_head,
    output cq_cnt_t   o_count
);

    cq_entry_t          r_mem [CQ_DEPTH];
    logic [CQ_AW-1:0]   r_wr_ptr;
    logic [CQ_AW-1:0]   r_rd_ptr;
    cq_cnt_t            r_count;

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/regfile_ctrl.sv
// Sequences renames, commits and post-mispredict busy-clear walks onto the
// register file's occupy and update ports.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    regfile_ctrl_if.slave bus
);

    state_e    r_state;
    reg_idx_t  r_idx;
    logic      r_ena;
    reg_idx_t  r_occ_reg;
    rob_tag_t  r_occ_tag;
    upd_op_e   r_upd_op;
    reg_idx_t  r_upd_reg;
    rob_tag_t  r_upd_tag;
    data_t     r_upd_value;

    logic      w_dec_fire;
    logic      w_rob_fire;
    logic      w_rob_keep;
    logic      w_bypass;
    logic      w_push;
    logic      w_pop;
    logic      w_drain_done;
    cq_entry_t w_rob_entry;
    cq_entry_t w_head;
    cq_cnt_t   w_count;

    // Renames are only taken in RUN so no pre-flush commit tag can alias a new rename.
    assign bus.dec_ready  = (r_state == RUN);
    // Ready comes from the registered count, so a full queue never sees push+pop.
    assign bus.rob_ready  = (w_count != CQ_FULL);
    assign bus.busy_flush = (r_state != RUN);

    assign w_dec_fire  = bus.dec_valid & bus.dec_ready;
    assign w_rob_fire  = bus.rob_valid & bus.rob_ready;
    assign w_rob_keep  = w_rob_fire & (bus.rob_rd != '0);
    assign w_rob_entry = '{rd: bus.rob_rd, tag: bus.rob_tag, value: bus.rob_value};
    // An empty queue in RUN lets the commit go straight to the port.
    assign w_bypass    = (r_state == RUN) & w_rob_keep & (w_count == '0);
    assign w_push      = w_rob_keep & ~w_bypass;
    assign w_pop       = (r_state != WALK) & (w_count != '0);
    // In DRAIN every non-empty cycle pops, so count <= 1 means empty after this edge.
    assign w_drain_done = (w_count <= cq_cnt_t'(1)) & ~w_rob_fire;

    regfile_ctrl_commit_queue u_cq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_rob_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Control FSM with registered occupy/update port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_idx       <= WALK_FIRST;
            r_ena       <= 1'b0;
            r_occ_reg   <= '0;
            r_occ_tag   <= '0;
            r_upd_op    <= UPD_NONE;
            r_upd_reg   <= '0;
            r_upd_tag   <= '0;
            r_upd_value <= '0;
        end else begin
            r_ena       <= 1'b0;
            r_occ_reg   <= '0;
            r_occ_tag   <= '0;
            r_upd_op    <= UPD_NONE;
            r_upd_reg   <= '0;
            r_upd_tag   <= '0;
            r_upd_value <= '0;

            if (w_pop) begin
                r_ena       <= 1'b1;
                r_upd_op    <= UPD_COMMIT;
                r_upd_reg   <= w_head.rd;
                r_upd_tag   <= w_head.tag;
                r_upd_value <= w_head.value;
            end else if (w_bypass) begin
                r_ena       <= 1'b1;
                r_upd_op    <= UPD_COMMIT;
                r_upd_reg   <= bus.rob_rd;
                r_upd_tag   <= bus.rob_tag;
                r_upd_value <= bus.rob_value;
            end

            if (w_dec_fire && (bus.dec_rd != '0)) begin
                r_ena     <= 1'b1;
                r_occ_reg <= bus.dec_rd;
                r_occ_tag <= bus.dec_tag;
            end

            case (r_state)
                RUN: begin
                    if (bus.flush) begin
                        r_state <= WALK;
                        r_idx   <= WALK_FIRST;
                    end
                end
                WALK: begin
                    r_ena     <= 1'b1;
                    r_upd_op  <= UPD_CLEAR;
                    r_upd_reg <= r_idx;
                    if (bus.flush) begin
                        r_idx <= WALK_FIRST;
                    end else if (r_idx == WALK_LAST) begin
                        r_state <= DRAIN;
                        r_idx   <= WALK_FIRST;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        r_state <= WALK;
                        r_idx   <= WALK_FIRST;
                    end else if (w_drain_done) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_idx   <= WALK_FIRST;
                end
            endcase
        end
    end

    assign bus.rf_ena       = r_ena;
    assign bus.rf_occ_reg   = r_occ_reg;
    assign bus.rf_occ_tag   = r_occ_tag;
    assign bus.rf_upd_op    = r_upd_op;
    assign bus.rf_upd_reg   = r_upd_reg;
    assign bus.rf_upd_tag   = r_upd_tag;
    assign bus.rf_upd_value = r_upd_value;

endmodule
